rect_cmd_arbiter: RTL

Round-robin command arbiter and sequencer for the rectangle rasterizer. It accepts rectangle draw commands from `N_REQ` independent requesters over valid/ready handshakes and grants one at a time. It latches the granted command, holds it stable on the rasterizer inputs, pulses the rasterizer `start`, and waits for its `done`. Completion is reported back with the originating requester ID. It sits between the shape-command producers and the single shared `rectangle` rasterizer instance.

---
 rtl/rect_cmd_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rect_cmd_arbiter.sv
// Round-robin arbiter and sequencer that feeds N_REQ rectangle command sources into one shared rasterizer.
// Latency: the command is held on rs_* from the edge after accept; rs_start is high for the next cycle; cmd_done follows rs_done by one cycle.
// Backpressure: one-hot req_ready is raised only in IDLE. Optional RECT_ARB_COORD_CHECK_EN completes inverted rectangles at once with cmd_err.
`timescale 1ns/1ps
module rect_cmd_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*57-1:0] req_cmd,
  output logic                rs_start,
  output logic [7:0]          rs_x0,
  output logic [7:0]          rs_y0,
  output logic [7:0]          rs_x1,
  output logic [7:0]          rs_y1,
  output logic                rs_fill,
  output logic [23:0]         rs_color,
  input  logic                rs_done,
  output logic                busy,
  output logic [ID_W-1:0]     cur_id,
  output logic                cmd_done,
  output logic [ID_W-1:0]     cmd_id,
  output logic                cmd_err
);

  localparam int CMD_W = 57;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  idx;
  logic [CMD_W-1:0] slot [N_REQ];
  logic [CMD_W-1:0] gnt_cmd;
  logic             accept;
  logic             cmd_bad;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      slot[i] = req_cmd[i*CMD_W +: CMD_W];
    end
  end

  // Scan from the farthest offset down so the nearest valid requester after rr_ptr wins.
  always_comb begin
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign gnt_cmd   = slot[gnt_id];
  assign accept    = (state == S_IDLE) && gnt_vld;
  assign req_ready = (accept && rst_n) ? (N_REQ'(1) << gnt_id) : '0;

`ifdef RECT_ARB_COORD_CHECK_EN
  logic err_q;

  assign cmd_bad = (gnt_cmd[40:33] < gnt_cmd[56:49]) || (gnt_cmd[32:25] < gnt_cmd[48:41]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= cmd_bad;
    end
  end

  assign cmd_err = (state == S_DONE) && err_q;
`else
  assign cmd_bad = 1'b0;
  assign cmd_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= ID_W'(N_REQ - 1);
      cur_id   <= '0;
      rs_x0    <= '0;
      rs_y0    <= '0;
      rs_x1    <= '0;
      rs_y1    <= '0;
      rs_fill  <= 1'b0;
      rs_color <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rs_x0    <= gnt_cmd[56:49];
            rs_y0    <= gnt_cmd[48:41];
            rs_x1    <= gnt_cmd[40:33];
            rs_y1    <= gnt_cmd[32:25];
            rs_fill  <= gnt_cmd[24];
            rs_color <= gnt_cmd[23:0];
            cur_id   <= gnt_id;
            rr_ptr   <= gnt_id;
            state    <= cmd_bad ? S_DONE : S_START;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT:  if (rs_done) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rs_start = (state == S_START);
  assign busy     = (state != S_IDLE);
  assign cmd_done = (state == S_DONE);
  assign cmd_id   = (state == S_DONE) ? cur_id : '0;

endmodule
